// File: rtl/mac_pkg.sv
// Shared types, widths and saturating arithmetic for the MAC sequencer.
// DATA_W, FRAC and LEN_W here set the widths used by every mac_* module.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC   = 9;
  localparam int LEN_W  = 8;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Symmetric clamp values: the most negative code is never produced by saturation.
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [PROD_W-1:0] ROUND_K = PROD_W'(1) << (FRAC - 1);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              sat;
  } sat_res_t;

  function automatic sat_res_t sat_norm(input logic [PROD_W-1:0] p);
    sat_res_t                      res;
    logic [PROD_W-1:0]             r;
    logic [PROD_W-FRAC-DATA_W:0]   top;
    r   = p + ROUND_K;
    top = r[PROD_W-1:FRAC+DATA_W-1];
    if ((top == '0) || (top == '1)) begin
      res.val = r[FRAC+DATA_W-1:FRAC];
      res.sat = 1'b0;
    end else begin
      res.val = r[PROD_W-1] ? SAT_NEG : SAT_POS;
      res.sat = 1'b1;
    end
    return res;
  endfunction

  function automatic sat_res_t sat_add(input logic [DATA_W-1:0] acc,
                                       input logic [DATA_W-1:0] n);
    sat_res_t          res;
    logic [DATA_W-1:0] sum;
    sum = acc + n;
    if (!acc[DATA_W-1] && !n[DATA_W-1] && sum[DATA_W-1]) begin
      res.val = SAT_POS;
      res.sat = 1'b1;
    end else if (acc[DATA_W-1] && n[DATA_W-1] && !sum[DATA_W-1]) begin
      res.val = SAT_NEG;
      res.sat = 1'b1;
    end else begin
      res.val = sum;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_sat_pipe.sv
// Three-stage multiply / round-saturate / saturating-accumulate datapath.
// clr_i loads the accumulator with init_i; sat_o pulses when a stage clamps.
module mac_sat_pipe
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] init_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              s1_valid_o,
  output logic              s2_valid_o,
  output logic              sat_o
);

  logic              s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  logic [PROD_W-1:0] a_ext, b_ext;
  sat_res_t          norm;
  sat_res_t          add;

  always_comb begin
    // Sign-extend before multiplying so the low PROD_W bits are the signed product.
    a_ext      = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    b_ext      = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    norm       = sat_norm(p_q);
    add        = sat_add(acc_q, n_q);

    s1_valid_d = in_valid_i;
    p_d        = in_valid_i ? (a_ext * b_ext) : p_q;
    s2_valid_d = s1_valid_q;
    n_d        = s1_valid_q ? norm.val : n_q;

    acc_d = acc_q;
    if (clr_i) begin
      acc_d = init_i;
    end else if (s2_valid_q) begin
      acc_d = add.val;
    end

    sat_o = (s1_valid_q & norm.sat) | (s2_valid_q & add.sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      s2_valid_q <= 1'b0;
      n_q        <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p_q        <= p_d;
      s2_valid_q <= s2_valid_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
    end
  end

  assign acc_o      = acc_q;
  assign s1_valid_o = s1_valid_q;
  assign s2_valid_o = s2_valid_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one saturating dot-product: length counter, handshakes, FSM.
// Optional MAC_SEQ_BIAS_EN adds a bias port that seeds the accumulator.
module mac_seq_ctrl
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
`ifdef MAC_SEQ_BIAS_EN
  input  logic [DATA_W-1:0] bias,
`endif
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_sat,
  output logic [LEN_W-1:0]  remaining,
  output state_e            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and a result is held until taken.

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              res_sat_q, res_sat_d;

  logic              accept;
  logic              clr;
  logic [DATA_W-1:0] init_val;
  logic [DATA_W-1:0] acc;
  logic              s1_valid, s2_valid, pipe_sat;

`ifdef MAC_SEQ_BIAS_EN
  assign init_val = bias;
`else
  assign init_val = '0;
`endif

  assign in_ready = (state_q == ST_RUN) && (remaining_q != '0);
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clr         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (len != '0) begin
            remaining_d = len;
            state_d     = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid && !s2_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    res_sat_d = clr ? 1'b0 : (res_sat_q | pipe_sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      res_sat_q   <= res_sat_d;
    end
  end

  mac_sat_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .init_i     (init_val),
    .in_valid_i (accept),
    .a_i        (in_a),
    .b_i        (in_b),
    .acc_o      (acc),
    .s1_valid_o (s1_valid),
    .s2_valid_o (s2_valid),
    .sat_o      (pipe_sat)
  );

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_valid ? acc : '0;
  assign res_sat   = res_sat_q;
  assign remaining = remaining_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed jobs plus randomized jobs
// checked against an arithmetic dot-product model.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_sat;
  logic [LEN_W-1:0]  remaining;
  state_e            dbg_state;
`ifdef MAC_SEQ_BIAS_EN
  logic [DATA_W-1:0] bias = '0;
`endif

  mac_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
`ifdef MAC_SEQ_BIAS_EN
    .bias      (bias),
`endif
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sat   (res_sat),
    .remaining (remaining),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int                tests_run    = 0;
  int                tests_failed = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_sat_q[$];

  logic [DATA_W-1:0] job_a[$];
  logic [DATA_W-1:0] job_b[$];

  logic [DATA_W-1:0] obs_data;
  logic              obs_sat;
  int                obs_lat;
  bit                obs_timeout;
  logic [LEN_W-1:0]  rem_start;
  logic [LEN_W-1:0]  rem_trace[$];

  // Dot product with round-half-up normalisation and symmetric clamping.
  function automatic void model_job(input longint init);
    longint maxv, minv, clampv, acc, p, n;
    bit     sat;
    maxv   = (longint'(1) << (DATA_W - 1)) - 1;
    minv   = -(longint'(1) << (DATA_W - 1));
    clampv = -maxv;
    acc    = init;
    sat    = 0;
    for (int i = 0; i < job_a.size(); i++) begin
      p = longint'($signed(job_a[i])) * longint'($signed(job_b[i]));
      n = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
      if (n > maxv) begin n = maxv; sat = 1; end
      else if (n < minv) begin n = clampv; sat = 1; end
      acc = acc + n;
      if (acc > maxv) begin acc = maxv; sat = 1; end
      else if (acc < minv) begin acc = clampv; sat = 1; end
    end
    exp_q.push_back(DATA_W'(acc));
    exp_sat_q.push_back(sat);
  endfunction

  // ---------------- driver tasks ----------------
  // gap_mode: 0 back-to-back, 1 random bubbles, 2 three idle cycles between pairs.
  task automatic run_job(input int n, input int gap_mode);
    int  idx;
    int  guard;
    bit  acc_now;
    model_job(0);
    rem_trace.delete();
    obs_timeout = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start     = 1'b0;
    rem_start = remaining;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      in_valid = (gap_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_a     = job_a[idx];
      in_b     = job_b[idx];
      acc_now  = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        idx++;
        rem_trace.push_back(remaining);
        if (gap_mode == 2 && idx < n) begin
          in_valid = 1'b0;
          repeat (3) begin @(posedge clk); #1; end
        end
      end
      guard++;
    end
    in_valid = 1'b0;
    if (idx < n) obs_timeout = 1;
    obs_lat = 0;
    while (!res_valid && obs_lat < 50) begin
      @(posedge clk); #1;
      obs_lat++;
    end
    if (!res_valid) obs_timeout = 1;
    obs_data = res_data;
    obs_sat  = res_sat;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic set_job(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int n);
    job_a.delete();
    job_b.delete();
    for (int i = 0; i < n; i++) begin
      job_a.push_back(a);
      job_b.push_back(b);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    #3;
    tests_run++;
    if ({busy, in_ready, res_valid, res_sat} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 0000", {busy, in_ready, res_valid, res_sat});
    end
    tests_run++;
    if (res_data !== '0 || remaining !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got data=%h rem=%0d required 0/0", res_data, remaining);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    #9 rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e;
    bit                es;
    set_job(16'h0200, 16'h0200, 4);
    run_job(4, 0);
    e  = exp_q.pop_front();
    es = exp_sat_q.pop_front();
    tests_run++;
    if (obs_timeout) begin
      tests_failed++;
      $display("FAIL b2b_timeout: job did not complete");
    end
    tests_run++;
    if (obs_data !== e || obs_data !== 16'h0800) begin
      tests_failed++;
      $display("FAIL b2b_data: got %h required %h", obs_data, e);
    end
    tests_run++;
    if (obs_sat !== es) begin
      tests_failed++;
      $display("FAIL b2b_sat: got %b required %b", obs_sat, es);
    end
    tests_run++;
    if (obs_lat != 3) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d required 3", obs_lat);
    end
    consume();
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_release: got valid=%b busy=%b required 0/0", res_valid, busy);
    end
  endtask

  task automatic test_gaps();
    logic [DATA_W-1:0] e;
    job_a.delete(); job_b.delete();
    job_a.push_back(16'h0400); job_b.push_back(16'h0600);
    job_a.push_back(16'hFE00); job_b.push_back(16'h0200);
    run_job(2, 2);
    e = exp_q.pop_front();
    void'(exp_sat_q.pop_front());
    tests_run++;
    if (obs_timeout || obs_data !== e || obs_data !== 16'h0A00) begin
      tests_failed++;
      $display("FAIL gaps_data: got %h (timeout=%0d) required %h", obs_data, obs_timeout, e);
    end
    tests_run++;
    if (rem_start !== 8'd2 || rem_trace.size() != 2) begin
      tests_failed++;
      $display("FAIL gaps_rem_start: got %0d (trace %0d) required 2", rem_start, rem_trace.size());
    end else begin
      tests_run++;
      if (rem_trace[0] !== 8'd1 || rem_trace[1] !== 8'd0) begin
        tests_failed++;
        $display("FAIL gaps_rem_trace: got %0d,%0d required 1,0", rem_trace[0], rem_trace[1]);
      end
    end
    consume();
  endtask

  task automatic test_product_sat();
    logic [DATA_W-1:0] e;
    bit                es;
    set_job(16'h7FFF, 16'h7FFF, 1);
    run_job(1, 0);
    e = exp_q.pop_front(); es = exp_sat_q.pop_front();
    tests_run++;
    if (obs_timeout || obs_data !== e || obs_sat !== es || e !== 16'h7FFF) begin
      tests_failed++;
      $display("FAIL prod_sat_pos: got %h/%b required %h/%b", obs_data, obs_sat, e, es);
    end
    consume();
    set_job(16'h8000, 16'h7FFF, 1);
    run_job(1, 0);
    e = exp_q.pop_front(); es = exp_sat_q.pop_front();
    tests_run++;
    if (obs_timeout || obs_data !== e || obs_sat !== es || e !== 16'h8001) begin
      tests_failed++;
      $display("FAIL prod_sat_neg: got %h/%b required %h/%b", obs_data, obs_sat, e, es);
    end
    consume();
  endtask

  task automatic test_accum_sat_hold();
    logic [DATA_W-1:0] e;
    bit                es;
    set_job(16'h7FFF, 16'h0200, 3);
    run_job(3, 0);
    e = exp_q.pop_front(); es = exp_sat_q.pop_front();
    tests_run++;
    if (obs_timeout || obs_data !== e || obs_sat !== es || es !== 1'b1) begin
      tests_failed++;
      $display("FAIL acc_sat: got %h/%b required %h/%b", obs_data, obs_sat, e, es);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== e || res_sat !== es || dbg_state !== ST_DONE) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got v=%b d=%h s=%b st=%0d required 1/%h/%b/%0d",
                 i, res_valid, res_data, res_sat, dbg_state, e, es, ST_DONE);
      end
    end
    start     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    res_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_start_ignored: got busy=%b st=%0d required 0/%0d", busy, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_len_zero();
    @(posedge clk); #1;
    start = 1'b1;
    len   = '0;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (res_valid !== 1'b1 || res_data !== '0 || res_sat !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL len_zero: got v=%b d=%h s=%b b=%b required 1/0000/0/1",
               res_valid, res_data, res_sat, busy);
    end
    consume();
  endtask

  task automatic test_reset_mid_job();
    logic [DATA_W-1:0] e;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 16'h0300;
    in_b     = 16'h0100;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    tests_run++;
    if (remaining !== 8'd3 || dbg_state !== ST_RUN) begin
      tests_failed++;
      $display("FAIL midjob_progress: got rem=%0d st=%0d required 3/%0d", remaining, dbg_state, ST_RUN);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, in_ready, res_valid, res_sat} !== 4'b0000 || res_data !== '0 ||
        remaining !== '0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL midjob_reset: got b=%b r=%b v=%b s=%b d=%h rem=%0d st=%0d required all 0",
               busy, in_ready, res_valid, res_sat, res_data, remaining, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    set_job(16'h0200, 16'h0200, 1);
    run_job(1, 0);
    e = exp_q.pop_front();
    void'(exp_sat_q.pop_front());
    tests_run++;
    if (obs_timeout || obs_data !== e || e !== 16'h0200) begin
      tests_failed++;
      $display("FAIL after_reset_job: got %h required %h", obs_data, e);
    end
    consume();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] edge_tbl[5];
    logic [DATA_W-1:0] e;
    bit                es;
    int                n;
    edge_tbl[0] = 16'h7FFF; edge_tbl[1] = 16'h8000; edge_tbl[2] = 16'h8001;
    edge_tbl[3] = 16'h0001; edge_tbl[4] = 16'hFFFF;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 12);
      job_a.delete(); job_b.delete();
      for (int i = 0; i < n; i++) begin
        job_a.push_back(($urandom_range(0, 4) == 0) ? edge_tbl[$urandom_range(0, 4)]
                                                    : DATA_W'($urandom_range(0, 4095) - 2048));
        job_b.push_back(($urandom_range(0, 4) == 0) ? edge_tbl[$urandom_range(0, 4)]
                                                    : DATA_W'($urandom_range(0, 65535)));
      end
      run_job(n, 1);
      e = exp_q.pop_front(); es = exp_sat_q.pop_front();
      tests_run++;
      if (obs_timeout || obs_data !== e || obs_sat !== es) begin
        tests_failed++;
        $display("FAIL random_job%0d: len=%0d got %h/%b (timeout=%0d) required %h/%b",
                 j, n, obs_data, obs_sat, obs_timeout, e, es);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_product_sat();
    test_accum_sat_hold();
    test_len_zero();
    test_reset_mid_job();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
